// File: rtl/jk_pkg.sv
// Shared constants for the JK flip-flop block.
// Command encodings are the concatenation {J,K}.
package jk_pkg;

    localparam logic [1:0] HOLD = 2'b00;
    localparam logic [1:0] CLR  = 2'b01;
    localparam logic [1:0] SET  = 2'b10;
    localparam logic [1:0] TGL  = 2'b11;

endpackage

// File: rtl/jk_flipflop_if.sv
// Groups the J/K request lines and the Q/Qbar state lines of the block.
// master drives requests; slave is the flip-flop side.
interface jk_flipflop_if #(
    parameter int WIDTH = 1
);

    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;

    modport master (
        output j,
        output k,
        input  q,
        input  qbar
    );

    modport slave (
        input  j,
        input  k,
        output q,
        output qbar
    );

endinterface

// File: rtl/jk_cell.sv
// Single-bit JK register with synchronous active-high reset.
// Reset wins over any J/K combination.
module jk_cell
    import jk_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VAL;
        end else begin
            unique case ({j, k})
                HOLD:    q <= q;
                CLR:     q <= 1'b0;
                SET:     q <= 1'b1;
                TGL:     q <= ~q;
                default: q <= q;
            endcase
        end
    end

endmodule

// File: rtl/jk_flipflop.sv
// WIDTH independent JK flip-flops with a shared clock and sync reset.
// Qbar is derived combinationally so it can never disagree with Q.
module jk_flipflop #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RESET_Q = '0
) (
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic             CLK,
    input  logic             rst,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell #(
            .RESET_VAL (RESET_Q[i])
        ) u_cell (
            .clk (CLK),
            .rst (rst),
            .j   (J[i]),
            .k   (K[i]),
            .q   (Q[i])
        );
    end

    assign Qbar = ~Q;

endmodule

// File: tb/tb_jk_flipflop.sv
// Directed and random checks of jk_flipflop at WIDTH=1.
// Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
module tb_jk_flipflop;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;
    logic mdl;

    jk_flipflop_if #(.WIDTH(1)) bus ();

    jk_flipflop #(
        .WIDTH   (1),
        .RESET_Q (1'b0)
    ) dut (
        .J    (bus.j),
        .K    (bus.k),
        .CLK  (clk),
        .rst  (rst),
        .Q    (bus.q),
        .Qbar (bus.qbar)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_pair(input string tag, input logic exp_q);
        check({tag, ".q"}, bus.q, exp_q);
        check({tag, ".qbar"}, bus.qbar, ~exp_q);
    endtask

    task automatic step(input logic j, input logic k, input logic r,
                        input logic exp_q, input string tag);
        @(negedge clk);
        bus.j = j;
        bus.k = k;
        rst   = r;
        @(posedge clk);
        #1;
        check_pair(tag, exp_q);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.j    = 1'b1;
        bus.k    = 1'b1;

        // reset held two edges with J=K=1
        step(1, 1, 1, 0, "rst_edge1");
        step(1, 1, 1, 0, "rst_edge2");

        // set, hold, clear, hold
        step(1, 0, 0, 1, "set");
        step(0, 0, 0, 1, "hold1");
        step(0, 1, 0, 0, "clr");
        step(0, 0, 0, 0, "hold0");

        // sustained toggle
        step(1, 1, 0, 1, "tgl1");
        step(1, 1, 0, 0, "tgl2");
        step(1, 1, 0, 1, "tgl3");
        step(1, 1, 0, 0, "tgl4");

        // Q=1, then glitch J/K/rst between edges
        step(1, 0, 0, 1, "preglitch");
        @(negedge clk);
        bus.j = 1'b0;
        bus.k = 1'b1;
        #1;
        check_pair("mid_clr", 1'b1);
        bus.j = 1'b1;
        bus.k = 1'b1;
        #1;
        check_pair("mid_tgl", 1'b1);
        rst = 1'b1;
        #1;
        check_pair("mid_rst", 1'b1);
        rst   = 1'b0;
        bus.j = 1'b1;
        bus.k = 1'b0;
        #1;
        bus.j = 1'b0;
        bus.k = 1'b0;
        @(posedge clk);
        #1;
        check_pair("post_glitch", 1'b1);

        // reset during toggling, then resume
        step(1, 1, 1, 0, "rst_tgl");
        step(1, 1, 0, 1, "resume1");
        step(1, 1, 0, 0, "resume2");

        // random J/K against a reference model
        step(0, 0, 1, 0, "rnd_rst");
        mdl = 1'b0;
        for (int i = 0; i < 20; i++) begin
            logic rj;
            logic rk;
            rj = 1'($urandom_range(0, 1));
            rk = 1'($urandom_range(0, 1));
            if (rj && rk) mdl = ~mdl;
            else if (rj)  mdl = 1'b1;
            else if (rk)  mdl = 1'b0;
            step(rj, rk, 0, mdl, $sformatf("rnd%0d", i));
            check($sformatf("rnd%0d.ne", i), bus.q !== bus.qbar, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/jk_flipflop.md
JK_FLIPFLOP -- requirements
Module: jk_flipflop

Interface
REQ-001 Parameter WIDTH, default 1: number of independent JK bit-cells; a value of 1 gives scalar ports.
REQ-002 Parameter RESET_Q, default 0 (WIDTH bits): value loaded into Q on reset.
REQ-003 CLK  input  1  clock; all state changes on the rising edge only.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 J  input  WIDTH  set request per bit.
REQ-006 K  input  WIDTH  clear request per bit.
REQ-007 Q  output  WIDTH  registered flip-flop state.
REQ-008 Qbar  output  WIDTH  bitwise complement of Q.
REQ-009 Port order SHALL be J, K, CLK, rst, Q, Qbar, so that positional instantiation is supported.

Function
REQ-010 On each rising CLK edge with rst=0, each bit i SHALL update from {J[i],K[i]} as follows:
- 00 -> hold Q[i].
- 01 -> Q[i]=0.
- 10 -> Q[i]=1.
- 11 -> Q[i]=~Q[i] (toggle).
REQ-011 Bits SHALL be fully independent; there is no cross-bit interaction.
REQ-012 Latency SHALL be one clock: a new Q is visible immediately after the sampling edge and stays stable until the next edge.
REQ-013 Qbar SHALL equal ~Q at all times, including during reset and after power-up once reset has been applied; Q and Qbar are never equal.
REQ-014 J/K changes between clock edges SHALL have no effect on Q or Qbar; the block is edge-triggered, not level-sensitive, and has no master-slave race.
REQ-015 Under sustained J=K=1, Q SHALL toggle every rising edge (period 2*CLK) with no oscillation within a cycle.
REQ-016 No handshake SHALL exist; inputs are sampled unconditionally every edge.
REQ-017 Before the first reset edge, Q and Qbar are undefined (X in simulation); no initial-value statement is permitted.

Reset
REQ-018 When rst=1 at a rising CLK edge, Q SHALL become RESET_Q and Qbar SHALL become ~RESET_Q, regardless of J and K.
REQ-019 Reset SHALL take priority over J/K when both are active in the same cycle, including J=K=1.
REQ-020 An asynchronous assertion of rst between edges SHALL not change the outputs until the next rising edge.
REQ-021 Deasserting rst mid-sequence SHALL resume normal JK operation from RESET_Q on the first edge with rst=0.

Structure
REQ-022 A shared package jk_pkg SHALL hold the JK command encodings as constants: HOLD=2'b00, CLR=2'b01, SET=2'b10, TGL=2'b11.
REQ-023 One sub-module, jk_cell (a single-bit JK register with sync reset), SHALL be instantiated WIDTH times via generate.
REQ-024 Qbar SHALL be driven combinationally as ~Q rather than by a separate register.

Verification
REQ-025 rst=1 for 2 edges with J=K=1 -> Q=0, Qbar=1 after the first edge and unchanged after the second.
REQ-026 rst=0; then J,K = 10, 00, 01, 00 on successive edges -> Q = 1, 1, 0, 0; Qbar always the complement.
REQ-027 rst=0, Q=0, J=K=1 held for 4 edges -> Q = 1, 0, 1, 0.
REQ-028 Q=1, then J=1, K=0 pulsed high and low between edges -> Q stays 1 and is updated only at edges.
REQ-029 While toggling with Q=1, assert rst with J=K=1 -> Q=0 at that edge; deassert rst -> toggling resumes with Q=1 on the next edge.
REQ-030 Random test: 20 cycles of random {J,K} after reset, checked each cycle against a reference model -> zero mismatches, and Q!=Qbar every cycle.
